// File: rtl/fp16_accumulator.sv
// FP16 (binary16) group accumulator.
// Adds a stream of FP16 products into a running sum and returns one FP16
// result per group. A group ends at the element tagged i_in_last.
// Each element passes through align, add and normalise stages, one cycle each.
// While the last of these stages runs, the next element of the same group can
// already be accepted, which gives a steady rate of one element per 3 cycles.
module fp16_accumulator #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [15:0]      i_in_data,
   input  logic             i_in_last,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [15:0]      o_out_data,
   output logic [CNT_W-1:0] o_out_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_OUT
   } state_t;

   // Control and result state
   state_t           r_state;
   logic [15:0]      r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_nan;
   logic             r_inf;
   logic             r_inf_sign;
   logic             r_out_valid;
   logic [15:0]      r_out_data;
   logic [CNT_W-1:0] r_out_count;

   // Datapath pipeline registers
   logic [15:0]      r_op;
   logic             r_last;
   logic [13:0]      r_big;
   logic [13:0]      r_small;
   logic [4:0]       r_exp;
   logic             r_sign;
   logic             r_sub;
   logic [14:0]      r_sum;

   // Align-stage wires
   logic [4:0]       w_a_exp, w_b_exp, w_l_exp, w_s_exp, w_diff;
   logic [10:0]      w_a_man, w_b_man, w_l_man, w_s_man;
   logic             w_l_sign, w_s_sign;
   logic [13:0]      w_s_ext, w_lost, w_s_aln;
   logic             w_op_nan, w_op_inf, w_acc_nan, w_acc_inf;

   // Normalise-stage wires
   logic [13:0]      w_n_m;
   logic [5:0]       w_n_e, w_e_r;
   logic [4:0]       w_lz, w_max_sh, w_sh;
   logic             w_rnd;
   logic [11:0]      w_mant;
   logic [10:0]      w_mant_r;
   logic [15:0]      w_res, w_acc_next;

   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_accept;

   // Number of leading zeros in a 14-bit significand (14 when all zero)
   function automatic logic [4:0] lz14(input logic [13:0] v);
      lz14 = 5'd14;
      for (int i = 0; i < 14; i++) begin
         if (v[i]) lz14 = 5'(13 - i);
      end
   endfunction

   // A new element is taken in idle, or during the final normalise cycle of a
   // non-last element so that the next align follows without a bubble.
   assign o_in_ready = ~i_rst & ((r_state == S_IDLE) | ((r_state == S_NORM) & ~r_last));
   assign w_accept   = i_in_valid & o_in_ready;
   assign w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_out_count = r_out_count;

   assign w_op_nan  = (r_op[14:10] == 5'h1F) & (r_op[9:0] != 10'd0);
   assign w_op_inf  = (r_op[14:10] == 5'h1F) & (r_op[9:0] == 10'd0);
   assign w_acc_nan = (r_acc[14:10] == 5'h1F) & (r_acc[9:0] != 10'd0);
   assign w_acc_inf = (r_acc[14:10] == 5'h1F) & (r_acc[9:0] == 10'd0);

   // Align: unpack both addends, order by magnitude, shift the smaller one
   always_comb begin
      // NOTE: every combinational output gets a value on every path; a missed
      // branch would otherwise infer a latch.
      w_a_exp = (r_acc[14:10] == 5'd0) ? 5'd1 : r_acc[14:10];
      w_a_man = {r_acc[14:10] != 5'd0, r_acc[9:0]};
      w_b_exp = (r_op[14:10] == 5'd0) ? 5'd1 : r_op[14:10];
      w_b_man = {r_op[14:10] != 5'd0, r_op[9:0]};
      if (r_acc[14:0] >= r_op[14:0]) begin
         w_l_exp  = w_a_exp;
         w_l_man  = w_a_man;
         w_l_sign = r_acc[15];
         w_s_exp  = w_b_exp;
         w_s_man  = w_b_man;
         w_s_sign = r_op[15];
      end else begin
         w_l_exp  = w_b_exp;
         w_l_man  = w_b_man;
         w_l_sign = r_op[15];
         w_s_exp  = w_a_exp;
         w_s_man  = w_a_man;
         w_s_sign = r_acc[15];
      end
      w_diff  = w_l_exp - w_s_exp;
      w_s_ext = {w_s_man, 3'b000};
      w_lost  = w_s_ext & ~(14'h3FFF << w_diff);
      if (w_diff >= 5'd14) begin
         w_s_aln = {13'd0, |w_s_man};
      end else begin
         w_s_aln = (w_s_ext >> w_diff) | {13'd0, |w_lost};
      end
   end

   // Normalise and round the raw sum to nearest-even, then apply specials
   always_comb begin
      w_lz     = lz14(r_sum[13:0]);
      w_max_sh = r_exp - 5'd1;
      w_sh     = (w_lz < w_max_sh) ? w_lz : w_max_sh;
      if (r_sum[14]) begin
         w_n_m = r_sum[14:1] | {13'd0, r_sum[0]};
         w_n_e = {1'b0, r_exp} + 6'd1;
      end else begin
         w_n_m = r_sum[13:0] << w_sh;
         w_n_e = {1'b0, r_exp} - {1'b0, w_sh};
      end
      w_rnd  = w_n_m[2] & (w_n_m[3] | w_n_m[1] | w_n_m[0]);
      w_mant = {1'b0, w_n_m[13:3]} + {11'd0, w_rnd};
      if (w_mant[11]) begin
         w_mant_r = w_mant[11:1];
         w_e_r    = w_n_e + 6'd1;
      end else begin
         w_mant_r = w_mant[10:0];
         w_e_r    = w_n_e;
      end
      if (w_e_r >= 6'd31) begin
         w_res = {r_sign, 5'h1F, 10'd0};
      end else if (w_mant_r == 11'd0) begin
         // Exact zero is +0 unless both addends were -0 (same sign, negative)
         w_res = {r_sign & ~r_sub, 15'd0};
      end else begin
         // A result without the hidden bit can only sit at exp=1: subnormal
         w_res = {r_sign, (w_mant_r[10] ? w_e_r[4:0] : 5'd0), w_mant_r[9:0]};
      end
      if (r_nan) begin
         w_acc_next = 16'h7FFF;
      end else if (r_inf) begin
         w_acc_next = {r_inf_sign, 5'h1F, 10'd0};
      end else begin
         w_acc_next = w_res;
      end
   end

   // Control FSM, datapath stages and registered result outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         // NOTE: only control and output state is reset; the pipeline
         // registers are always written before they are read.
         r_state     <= S_IDLE;
         r_acc       <= 16'h0000;
         r_cnt       <= '0;
         r_nan       <= 1'b0;
         r_inf       <= 1'b0;
         r_inf_sign  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= 16'h0000;
         r_out_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op    <= i_in_data;
                  r_last  <= i_in_last;
                  r_cnt   <= w_cnt_inc;
                  r_state <= S_ALIGN;
               end
            end
            S_ALIGN: begin
               r_big   <= {w_l_man, 3'b000};
               r_small <= w_s_aln;
               r_exp   <= w_l_exp;
               r_sign  <= w_l_sign;
               r_sub   <= w_l_sign ^ w_s_sign;
               if (w_op_nan | w_acc_nan | (w_op_inf & w_acc_inf & (r_op[15] != r_acc[15]))) begin
                  r_nan <= 1'b1;
               end
               if (w_op_inf) begin
                  r_inf      <= 1'b1;
                  r_inf_sign <= r_op[15];
               end else if (w_acc_inf) begin
                  r_inf      <= 1'b1;
                  r_inf_sign <= r_acc[15];
               end
               r_state <= S_ADD;
            end
            S_ADD: begin
               r_sum   <= r_sub ? ({1'b0, r_big} - {1'b0, r_small})
                                : ({1'b0, r_big} + {1'b0, r_small});
               r_state <= S_NORM;
            end
            S_NORM: begin
               r_acc <= w_acc_next;
               if (r_last) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_acc_next;
                  r_out_count <= r_cnt;
                  r_state     <= S_OUT;
               end else if (w_accept) begin
                  r_op    <= i_in_data;
                  r_last  <= i_in_last;
                  r_cnt   <= w_cnt_inc;
                  r_state <= S_ALIGN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_OUT: begin
               if (i_out_ready) begin
                  r_acc       <= 16'h0000;
                  r_cnt       <= '0;
                  r_nan       <= 1'b0;
                  r_inf       <= 1'b0;
                  r_inf_sign  <= 1'b0;
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp16_accumulator.sv
// Self-checking bench for fp16_accumulator: directed cases plus randomized
// groups compared against an exact-arithmetic FP16 reference model.
module tb_fp16_accumulator;

   localparam int CNT_W  = 16;
   localparam int BUDGET = 64;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_data;
   logic [CNT_W-1:0] out_count;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   logic [15:0] grp[$];

   fp16_accumulator #(.CNT_W(CNT_W)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_data   (in_data),
      .i_in_last   (in_last),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_data  (out_data),
      .o_out_count (out_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model: exact integer sum, then RNE ----------
   function automatic longint fp_to_int(input logic [15:0] f);
      longint mag;
      int     e;
      e = int'(f[14:10]);
      if (e == 0) mag = longint'(f[9:0]);
      else        mag = longint'({1'b1, f[9:0]}) << (e - 1);
      return f[15] ? -mag : mag;
   endfunction

   function automatic logic [15:0] int_to_fp(input longint s);
      logic   sgn;
      longint v, q, rem, half;
      int     k;
      sgn = (s < 0);
      v   = sgn ? -s : s;
      k   = 0;
      while ((v >> k) >= 2048) k++;
      q = v >> k;
      if (k > 0) begin
         rem  = v - (q << k);
         half = longint'(1) << (k - 1);
         if (rem > half || (rem == half && q[0])) q++;
         if (q == 2048) begin
            q = 1024;
            k++;
         end
      end
      if (k + 1 >= 31) return {sgn, 15'h7C00};
      if (q < 1024)    return {sgn, 5'd0, q[9:0]};
      return {sgn, 5'(k + 1), q[9:0]};
   endfunction

   function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
      logic   a_nan, b_nan, a_inf, b_inf;
      longint s;
      a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 0);
      b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 0);
      a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 0);
      b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 0);
      if (a_nan || b_nan) return 16'h7FFF;
      if (a_inf && b_inf) return (a[15] == b[15]) ? a : 16'h7FFF;
      if (a_inf) return a;
      if (b_inf) return b;
      s = fp_to_int(a) + fp_to_int(b);
      if (s == 0) return (a[15] && b[15]) ? 16'h8000 : 16'h0000;
      return int_to_fp(s);
   endfunction

   function automatic logic [15:0] model_group();
      logic [15:0] acc;
      acc = 16'h0000;
      foreach (grp[i]) acc = fp_add(acc, grp[i]);
      return acc;
   endfunction

   function automatic logic [15:0] rand_fp();
      int          k;
      logic [15:0] r;
      k = $urandom_range(0, 31);
      r = 16'($urandom);
      if (k == 0) begin
         case ($urandom_range(0, 4))
            0:       r = 16'h7C00;
            1:       r = 16'hFC00;
            2:       r = 16'h7E01;
            3:       r = 16'h0000;
            default: r = 16'h8000;
         endcase
      end else if (k < 4) begin
         r[14:10] = 5'd0;
      end else if (k < 6) begin
         r[14:10] = 5'($urandom_range(27, 30));
      end else if (k >= 8) begin
         r[14:10] = 5'($urandom_range(10, 18));
      end
      return r;
   endfunction

   // ---------------- stimulus helpers (called at a negedge) ----------------
   // t_acc is the index of the clock edge that completes the handshake
   task automatic send(input logic [15:0] d, input logic last, output int t_acc);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      n = 0;
      while (!in_ready && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", 32'(n < BUDGET), 32'd1);
      t_acc = cyc + 1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // t_out is the index of the clock edge that raised out_valid
   task automatic get_result(input bit stall, output logic [15:0] d,
                             output logic [CNT_W-1:0] c, output int t_out);
      int n;
      n = 0;
      while (!out_valid && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      check("out_valid_wait", 32'(n < BUDGET), 32'd1);
      t_out = cyc;
      d = out_data;
      c = out_count;
      if (stall) begin
         out_ready = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_group(input string tag, input bit use_exp,
                            input logic [15:0] exp_data, input bit rnd);
      logic [15:0]      d, e;
      logic [CNT_W-1:0] c;
      int               t;
      e = use_exp ? exp_data : model_group();
      foreach (grp[i]) begin
         if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
         send(grp[i], (i == grp.size() - 1), t);
      end
      get_result(rnd, d, c, t);
      check({tag, "_data"}, 32'(d), 32'(e));
      check({tag, "_count"}, 32'(c), 32'(grp.size()));
   endtask

   task automatic dir(input string tag, input int n, input logic [15:0] v0,
                      input logic [15:0] v1, input logic [15:0] v2, input logic [15:0] exp);
      grp = {};
      grp.push_back(v0);
      if (n > 1) grp.push_back(v1);
      if (n > 2) grp.push_back(v2);
      run_group(tag, 1'b1, exp, 1'b0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int               t0, t1, t2, t3;
      logic [15:0]      d;
      logic [CNT_W-1:0] c;

      rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0; out_ready = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_count", 32'(out_count), 32'd0);
      check("rst_in_ready_held", 32'(in_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd1);

      // Basic sum with in_valid held high: 1 + 2 + 3 = 6
      send(16'h3C00, 1'b0, t0);
      send(16'h4000, 1'b0, t1);
      send(16'h4200, 1'b1, t2);
      get_result(1'b0, d, c, t3);
      check("basic_accept_gap1", 32'(t1 - t0), 32'd3);
      check("basic_accept_gap2", 32'(t2 - t1), 32'd3);
      check("basic_out_latency", 32'(t3 - t0), 32'd9);
      check("basic_data", 32'(d), 32'h4600);
      check("basic_count", 32'(c), 32'd3);

      // Directed arithmetic and special-value cases
      dir("rnd_tie",   2, 16'h3C00, 16'h1000, 16'h0000, 16'h3C00);
      dir("rnd_up",    2, 16'h3C01, 16'h1000, 16'h0000, 16'h3C02);
      dir("rnd_below", 2, 16'h3C00, 16'h0C00, 16'h0000, 16'h3C00);
      dir("cancel",    2, 16'h4500, 16'hC500, 16'h0000, 16'h0000);
      dir("sub_sub",   2, 16'h0001, 16'h0001, 16'h0000, 16'h0002);
      dir("sub_mix",   2, 16'h0400, 16'h8001, 16'h0000, 16'h03FF);
      dir("ovf",       2, 16'h7BFF, 16'h7BFF, 16'h0000, 16'h7C00);
      dir("ovf_hold",  3, 16'h7BFF, 16'h7BFF, 16'hC000, 16'h7C00);
      dir("inf_mix",   2, 16'h7C00, 16'hFC00, 16'h0000, 16'h7FFF);
      dir("nan",       3, 16'h3C00, 16'hFFFF, 16'h3C00, 16'h7FFF);
      dir("neg_inf",   2, 16'hFC00, 16'h3C00, 16'h0000, 16'hFC00);
      dir("neg_zero",  1, 16'h8000, 16'h0000, 16'h0000, 16'h0000);
      dir("single",    1, 16'hC248, 16'h0000, 16'h0000, 16'hC248);

      // Reset taken while the first element is in the add stage
      send(16'h3C00, 1'b0, t0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_in_ready", 32'(in_ready), 32'd0);
      repeat (2) begin
         @(negedge clk);
         check("abort_out_valid", 32'(out_valid), 32'd0);
         check("abort_out_data", 32'(out_data), 32'd0);
         check("abort_in_ready_held", 32'(in_ready), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      check("abort_in_ready_after", 32'(in_ready), 32'd1);
      dir("after_abort", 2, 16'h4000, 16'h4200, 16'h0000, 16'h4500);

      // Output backpressure: result held, no new input taken
      out_ready = 1'b0;
      send(16'h3C00, 1'b0, t0);
      send(16'h3C00, 1'b1, t1);
      while (!out_valid && cyc < t1 + BUDGET) @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h4400;
      in_last  = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_out_data", 32'(out_data), 32'h4000);
         check("bp_out_count", 32'(out_count), 32'd2);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_released", 32'(out_valid), 32'd0);
      dir("bp_next", 1, 16'h4400, 16'h0000, 16'h0000, 16'h4400);

      // Randomized groups against the reference model
      for (int g = 0; g < 150; g++) begin
         int len;
         len = $urandom_range(1, 6);
         grp = {};
         for (int i = 0; i < len; i++) grp.push_back(rand_fp());
         run_group("rand", 1'b0, 16'h0000, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
